// File: rtl/cdc_fifo_src_arb_pkg.sv
// Types shared by the cdc_fifo_src_arb slice.
// lock_e: grant state of the arbiter. IDLE re-arbitrates every cycle. LOCKED
// holds the current winner until its grant ends.
package cdc_fifo_src_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_e;

endpackage

// File: rtl/cdc_fifo_src_arb_rr_pick.sv
// Combinational round-robin picker. It rotates the request vector so that
// bit prio_i lands at position 0, then takes the lowest set bit.
// Ports:
//   req_i  - request vector, one bit per requester
//   prio_i - round-robin pointer, always < NumIn
//   idx_o  - index of the first request at or after prio_i, wrapping
//   any_o  - at least one request is set
module cdc_fifo_src_arb_rr_pick #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned IdxWidth = $clog2(NumIn)
) (
  input  logic [NumIn-1:0]    req_i,
  input  logic [IdxWidth-1:0] prio_i,
  output logic [IdxWidth-1:0] idx_o,
  output logic                any_o
);

  localparam logic [IdxWidth:0] NumInW = (IdxWidth+1)'(NumIn);

  logic [NumIn-1:0]    req_rot;
  logic [IdxWidth-1:0] offset;
  logic [IdxWidth:0]   idx_sum;

  // Doubling the vector before the shift makes the rotation wrap at NumIn
  // rather than at a power of two.
  assign req_rot = NumIn'({req_i, req_i} >> prio_i);
  assign any_o   = |req_i;

  // Trailing-one search. The scan runs downwards, so the lowest set bit wins.
  always_comb begin
    offset = '0;
    for (int unsigned k = NumIn; k > 0; k--) begin
      if (req_rot[k-1]) offset = IdxWidth'(k - 1);
    end
  end

  // The sum is one bit wider so the compare sees the true value before the wrap.
  assign idx_sum = {1'b0, prio_i} + {1'b0, offset};

  always_comb begin
    idx_o = idx_sum[IdxWidth-1:0];
    if (idx_sum >= NumInW) idx_o = IdxWidth'(idx_sum - NumInW);
  end

endmodule

// File: rtl/cdc_fifo_src_arb.sv
// Round-robin, burst-locking arbiter in front of the source port of a
// cdc_fifo_gray. The winner keeps the FIFO until its burst ends or until
// MaxBeats beats have transferred. oup_idx_o tells the destination domain
// which requester owns the beat.
// Ports:
//   clk_i, rst_ni         - source clock, asynchronous active-low reset
//   inp_valid_i/ready_o   - per-requester handshake
//   inp_data_i/last_i     - per-requester payload and end-of-burst
//   oup_valid_o/ready_i   - handshake with the FIFO source port
//   oup_data_o            - payload of the winner
//   oup_idx_o             - index of the winner
//   oup_last_o            - end of grant: the requester's last, or a forced split
module cdc_fifo_src_arb
  import cdc_fifo_src_arb_pkg::*;
#(
  parameter int unsigned NumIn    = 4,
  parameter type         T        = logic [31:0],
  parameter int unsigned MaxBeats = 16,
  parameter int unsigned IdxWidth = $clog2(NumIn)
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NumIn-1:0]    inp_valid_i,
  output logic [NumIn-1:0]    inp_ready_o,
  input  T                    inp_data_i [NumIn],
  input  logic [NumIn-1:0]    inp_last_i,
  output logic                oup_valid_o,
  input  logic                oup_ready_i,
  output T                    oup_data_o,
  output logic [IdxWidth-1:0] oup_idx_o,
  output logic                oup_last_o
);

  localparam int unsigned         CntWidth = $clog2(MaxBeats + 1);
  localparam logic [CntWidth-1:0] CntLast  = CntWidth'(MaxBeats - 1);
  localparam logic [IdxWidth-1:0] IdxLast  = IdxWidth'(NumIn - 1);

  lock_e               lock_q, lock_d;
  logic [IdxWidth-1:0] idx_q, idx_d, prio_q, prio_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0] pick_idx, win;
  logic                pick_any, grant_end, hs;

  cdc_fifo_src_arb_rr_pick #(
    .NumIn    (NumIn),
    .IdxWidth (IdxWidth)
  ) i_pick (
    .req_i  (inp_valid_i),
    .prio_i (prio_q),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // Output path. Zero latency from the requesters to the FIFO. The FIFO's
  // ready comes from its registers only, so no combinational loop forms.
  always_comb begin
    win         = (lock_q == LOCKED) ? idx_q : pick_idx;
    oup_valid_o = (lock_q == LOCKED) ? inp_valid_i[idx_q] : pick_any;
    oup_data_o  = inp_data_i[win];
    oup_idx_o   = win;
    grant_end   = inp_last_i[win] | (cnt_q == CntLast);
    // Gated with valid so that an idle port shows no last and no ready.
    oup_last_o  = oup_valid_o & grant_end;
    hs          = oup_valid_o & oup_ready_i;
    inp_ready_o = '0;
    if (oup_valid_o) inp_ready_o[win] = oup_ready_i;
  end

  always_comb begin
    lock_d = lock_q;
    idx_d  = idx_q;
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (hs && grant_end) begin
      lock_d = IDLE;
      prio_d = (win == IdxLast) ? '0 : win + IdxWidth'(1);
      cnt_d  = '0;
    end else begin
      if (hs) cnt_d = cnt_q + CntWidth'(1);
      // Locking on a stalled beat keeps the choice stable while the FIFO is full.
      if (oup_valid_o && (lock_q == IDLE)) begin
        lock_d = LOCKED;
        idx_d  = win;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_q <= IDLE;
      idx_q  <= '0;
      prio_q <= '0;
      cnt_q  <= '0;
    end else begin
      lock_q <= lock_d;
      idx_q  <= idx_d;
      prio_q <= prio_d;
      cnt_q  <= cnt_d;
    end
  end

`ifndef COMMON_CELLS_ASSERTS_OFF
  for (genvar i = 0; i < NumIn; i++) begin : gen_inp_stable
    a_inp_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
      (inp_valid_i[i] && !inp_ready_o[i]) |=>
        (inp_valid_i[i] && $stable(inp_data_i[i]) && $stable(inp_last_i[i])));
  end

  a_num_in    : assert property (@(posedge clk_i) NumIn >= 2);
  a_max_beats : assert property (@(posedge clk_i) MaxBeats >= 1);

  a_idx_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (oup_valid_o && !oup_ready_i) |=> $stable(oup_idx_o));
`endif

endmodule

// File: tb/tb_cdc_fifo_src_arb.sv
module tb_cdc_fifo_src_arb;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  inp_valid, inp_ready, inp_last;
  logic [31:0]   inp_data [N];
  logic          oup_valid, oup_ready, oup_last;
  logic [31:0]   oup_data;
  logic [IW-1:0] oup_idx;

  always #5 clk = ~clk;

  cdc_fifo_src_arb #(
    .NumIn    (N),
    .T        (logic [31:0]),
    .MaxBeats (MB)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .inp_valid_i (inp_valid),
    .inp_ready_o (inp_ready),
    .inp_data_i  (inp_data),
    .inp_last_i  (inp_last),
    .oup_valid_o (oup_valid),
    .oup_ready_i (oup_ready),
    .oup_data_o  (oup_data),
    .oup_idx_o   (oup_idx),
    .oup_last_o  (oup_last)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: the current owner of the FIFO (-1 = nobody), the
  // round-robin pointer and the number of beats already sent in this grant.
  int m_owner = -1;
  int m_prio  = 0;
  int m_cnt   = 0;

  // Requester drivers.
  int left [N];
  int seq  [N];
  int bq   [N][$];
  bit consumed [N];
  bit rand_mode  = 0;
  bit rand_ready = 0;
  logic rdy_fix  = 1'b1;
  bit bp_check   = 0;

  typedef struct {
    int idx;
    bit last;
    int cyc;
  } xfer_t;
  xfer_t xlog[$];

  function automatic logic [31:0] mk(int i, int s);
    return {i[7:0], s[23:0]};
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic drive();
    bit hold_off;
    for (int i = 0; i < N; i++) begin
      hold_off = 0;
      if (consumed[i]) begin
        consumed[i] = 0;
        left[i]--;
        seq[i]++;
        inp_valid[i] = 1'b0;
        inp_last[i]  = 1'b0;
        hold_off = rand_mode && (left[i] > 0) && ($urandom_range(3) == 0);
      end
      if (!inp_valid[i] && !hold_off) begin
        if (left[i] == 0) begin
          if (bq[i].size() > 0) left[i] = bq[i].pop_front();
          else if (rand_mode && $urandom_range(2) == 0) left[i] = int'($urandom_range(7, 1));
        end
        if (left[i] > 0) begin
          inp_valid[i] = 1'b1;
          inp_data[i]  = mk(i, seq[i]);
          inp_last[i]  = (left[i] == 1);
        end
      end
    end
    oup_ready = rand_ready ? ($urandom_range(9) < 7) : rdy_fix;
  endtask

  // One clock cycle: drive at the negedge, check 1 ns later, update at the posedge.
  task automatic step();
    int w;
    bit mv, mend, hs, found;
    logic [N-1:0] er, dut_rdy;
    drive();
    #1;
    w = 0;
    mv = 0;
    if (m_owner >= 0) begin
      w  = m_owner;
      mv = inp_valid[w];
    end else begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        if (!found && inp_valid[(m_prio + k) % N]) begin
          w = (m_prio + k) % N;
          found = 1;
        end
      end
      mv = found;
    end
    mend = mv && (inp_last[w] || (m_cnt == MB - 1));
    hs   = mv && oup_ready;
    er   = hs ? (N'(1) << w) : '0;
    chk("oup_valid", oup_valid, mv);
    chk("inp_ready", inp_ready, er);
    chk("oup_last", oup_last, mend);
    if (mv) begin
      chk("oup_idx", oup_idx, w);
      chk("oup_data", oup_data, mk(w, seq[w]));
    end
    if (bp_check) begin
      chk("bp_idx", oup_idx, 2);
      chk("bp_ready", inp_ready, 0);
      chk("bp_data", oup_data, mk(2, seq[2]));
    end
    dut_rdy = inp_ready;
    if (oup_valid && oup_ready) xlog.push_back('{int'(oup_idx), oup_last, cyc});
    @(posedge clk);
    cyc++;
    for (int i = 0; i < N; i++) if (inp_valid[i] && dut_rdy[i]) consumed[i] = 1;
    if (rst_n) begin
      if (hs && mend) begin
        m_owner = -1;
        m_prio  = (w + 1) % N;
        m_cnt   = 0;
      end else if (hs) begin
        m_cnt++;
        m_owner = w;
      end else if (mv) begin
        m_owner = w;
      end
    end
    @(negedge clk);
  endtask

  task automatic run_until(int n, int budget, string name);
    int b;
    b = 0;
    while (xlog.size() < n && b < budget) begin
      step();
      b++;
    end
    checks++;
    if (xlog.size() < n) begin
      errors++;
      $display("FAIL %s: timeout, got %0d transfers expected %0d", name, xlog.size(), n);
    end
  endtask

  task automatic chk_log(string name, int k, int exp_idx, bit exp_last);
    checks++;
    if (k >= xlog.size()) begin
      errors++;
      $display("FAIL %s[%0d]: missing transfer, got %0d expected more than %0d", name, k, xlog.size(), k);
    end else begin
      chk({name, "_idx"}, xlog[k].idx, exp_idx);
      chk({name, "_last"}, xlog[k].last, exp_last);
      chk({name, "_gap"}, xlog[k].cyc - xlog[0].cyc, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish before 1 ms");
    $fatal(1);
  end

  initial begin
    inp_valid = '0;
    inp_last  = '0;
    oup_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      inp_data[i] = '0;
      left[i] = 0;
      seq[i] = 0;
      consumed[i] = 0;
    end
    #3;
    chk("reset_valid", oup_valid, 0);
    chk("reset_ready", inp_ready, 0);
    chk("reset_idx", oup_idx, 0);
    chk("reset_last", oup_last, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Round robin over single-beat bursts.
    for (int i = 0; i < N; i++) begin
      bq[i].push_back(1);
      bq[i].push_back(1);
    end
    run_until(8, 40, "rr");
    for (int k = 0; k < 8; k++) chk_log("rr", k, k % 4, 1'b1);

    // Burst lock: one req0 beat moves the pointer to 1, then req1 holds a 3-beat burst.
    xlog.delete();
    bq[0].push_back(1);
    run_until(1, 10, "lock_pre");
    xlog.delete();
    bq[1].push_back(3);
    bq[0].push_back(1);
    bq[2].push_back(1);
    run_until(5, 30, "lock");
    chk_log("lock", 0, 1, 1'b0);
    chk_log("lock", 1, 1, 1'b0);
    chk_log("lock", 2, 1, 1'b1);
    chk_log("lock", 3, 2, 1'b1);
    chk_log("lock", 4, 0, 1'b1);

    // Forced split of a 10-beat burst at MaxBeats = 4.
    xlog.delete();
    bq[3].push_back(10);
    run_until(10, 40, "split");
    for (int k = 0; k < 10; k++) chk_log("split", k, 3, (k == 3) || (k == 7) || (k == 9));

    // Backpressure: req2 stalls 7 cycles while req0 joins.
    xlog.delete();
    rdy_fix = 1'b0;
    bp_check = 1;
    bq[2].push_back(1);
    step();
    bq[0].push_back(1);
    repeat (6) step();
    bp_check = 0;
    rdy_fix = 1'b1;
    run_until(2, 10, "bp");
    chk_log("bp", 0, 2, 1'b1);
    chk_log("bp", 1, 0, 1'b1);

    // Reset in the middle of a 6-beat req0 burst.
    xlog.delete();
    bq[0].push_back(6);
    run_until(2, 10, "rst_pre");
    drive();
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      bq[i].delete();
      consumed[i] = 0;
    end
    inp_valid = 4'b0010;
    inp_data[1] = mk(1, seq[1]);
    inp_last = '0;
    #1;
    chk("async_valid", oup_valid, 1);
    chk("async_idx", oup_idx, 1);
    inp_valid = '0;
    #1;
    chk("rst_valid", oup_valid, 0);
    chk("rst_ready", inp_ready, 0);
    chk("rst_idx", oup_idx, 0);
    chk("rst_last", oup_last, 0);
    m_owner = -1;
    m_prio  = 0;
    m_cnt   = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    xlog.delete();
    bq[0].push_back(4);
    bq[1].push_back(1);
    run_until(5, 20, "post_rst");
    chk_log("post_rst", 0, 0, 1'b0);
    chk_log("post_rst", 1, 0, 1'b0);
    chk_log("post_rst", 2, 0, 1'b0);
    chk_log("post_rst", 3, 0, 1'b1);
    chk_log("post_rst", 4, 1, 1'b1);

    // Random traffic with random FIFO backpressure and gaps inside bursts.
    rand_mode  = 1;
    rand_ready = 1;
    repeat (3000) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
